// File: rtl/conv_weight_loader_if.sv
// Parameter word stream into the conv weight loader.
// Handshake: a word transfers on a rising clk edge where valid and ready are
// both high; the source holds data stable while valid is high and ready is
// low, and ready never depends on valid.
interface conv_weight_loader_if;
    logic [15:0] data;
    logic        valid;
    logic        ready;

    // Parameter source (host DMA or test harness)
    modport master (
        output data,
        output valid,
        input  ready
    );

    // Loader side
    modport slave (
        input  data,
        input  valid,
        output ready
    );
endinterface

// File: rtl/conv_weight_loader.sv
// conv_weight_loader: walks a flat 16-bit parameter stream into the weight
// write port of one conv layer. The regions are kernel, bias, MACC
// coefficient and layer scale, in that order.
// Optional feature macro: CONV_WEIGHT_LOADER_CHECKSUM_EN adds a trailing
// checksum word, a CHECK state and the sticky checksum_err output.
module conv_weight_loader #(
    parameter int unsigned KERNEL_0              = 3,
    parameter int unsigned KERNEL_1              = 3,
    parameter int unsigned IN_CHANNEL            = 2,
    parameter int unsigned OUT_CHANNEL           = 2,
    parameter int unsigned KERNEL_BASE_ADDR      = 0,
    parameter int unsigned BIAS_BASE_ADDR        = 36,
    parameter int unsigned MACC_COEFF_BASE_ADDR  = 38,
    parameter int unsigned LAYER_SCALE_BASE_ADDR = 39
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    conv_weight_loader_if.slave  s,
    output logic [15:0]          weight_wr_data,
    output logic [31:0]          weight_wr_addr,
    output logic                 weight_wr_en,
    output logic                 busy,
    output logic                 done,
`ifdef CONV_WEIGHT_LOADER_CHECKSUM_EN
    output logic                 checksum_err,
`endif
    output logic [2:0]           state_dbg
);

    // Region sizes in words. MACC and SCALE are single words.
    localparam logic [31:0] N_K = 32'(KERNEL_0 * KERNEL_1 * IN_CHANNEL * OUT_CHANNEL);
    localparam logic [31:0] N_B = 32'(OUT_CHANNEL);

    localparam logic [31:0] K_BASE = 32'(KERNEL_BASE_ADDR);
    localparam logic [31:0] B_BASE = 32'(BIAS_BASE_ADDR);
    localparam logic [31:0] M_BASE = 32'(MACC_COEFF_BASE_ADDR);
    localparam logic [31:0] S_BASE = 32'(LAYER_SCALE_BASE_ADDR);

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_KERNEL = 3'd1,
        ST_BIAS   = 3'd2,
        ST_MACC   = 3'd3,
        ST_SCALE  = 3'd4,
`ifdef CONV_WEIGHT_LOADER_CHECKSUM_EN
        ST_CHECK  = 3'd5,
`endif
        ST_DONE   = 3'd6
    } state_t;

    state_t      state;
    logic [31:0] idx;

    // Decoded from state each cycle
    logic        in_write_region;
    logic        region_last;
    logic [31:0] cur_base;
    state_t      next_region;
    logic        wr_accept;

`ifdef CONV_WEIGHT_LOADER_CHECKSUM_EN
    logic [15:0] sum;
    logic        chk_accept;
`endif

    // Region decode: which base applies, whether this is the region's last word,
    // and where the sequence goes once that word is accepted
    always_comb begin
        in_write_region = 1'b0;
        region_last     = 1'b0;
        cur_base        = K_BASE;
        next_region     = ST_IDLE;
        unique case (state)
            ST_KERNEL: begin
                in_write_region = 1'b1;
                region_last     = (idx == N_K - 32'd1);
                cur_base        = K_BASE;
                next_region     = ST_BIAS;
            end
            ST_BIAS: begin
                in_write_region = 1'b1;
                region_last     = (idx == N_B - 32'd1);
                cur_base        = B_BASE;
                next_region     = ST_MACC;
            end
            ST_MACC: begin
                in_write_region = 1'b1;
                region_last     = 1'b1;
                cur_base        = M_BASE;
                next_region     = ST_SCALE;
            end
            ST_SCALE: begin
                in_write_region = 1'b1;
                region_last     = 1'b1;
                cur_base        = S_BASE;
`ifdef CONV_WEIGHT_LOADER_CHECKSUM_EN
                next_region     = ST_CHECK;
`else
                next_region     = ST_DONE;
`endif
            end
            default: begin
                in_write_region = 1'b0;
                region_last     = 1'b0;
                cur_base        = K_BASE;
                next_region     = ST_IDLE;
            end
        endcase
    end

    // ready follows state alone so the source may hold valid low indefinitely
`ifdef CONV_WEIGHT_LOADER_CHECKSUM_EN
    assign s.ready    = in_write_region | (state == ST_CHECK);
    assign chk_accept = s.valid & (state == ST_CHECK);
`else
    assign s.ready    = in_write_region;
`endif

    // Only parameter words produce writes; the checksum word never reaches conv
    assign wr_accept = s.valid & in_write_region;

    assign state_dbg = state;

    // Sequencer: state, word index, registered write port and status outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            state          <= ST_IDLE;
            idx            <= 32'd0;
            weight_wr_en   <= 1'b0;
            weight_wr_data <= 16'd0;
            weight_wr_addr <= 32'd0;
            busy           <= 1'b0;
            done           <= 1'b0;
`ifdef CONV_WEIGHT_LOADER_CHECKSUM_EN
            sum            <= 16'd0;
            checksum_err   <= 1'b0;
`endif
        end else begin
            // One write strobe per accepted parameter word, one cycle later
            weight_wr_en <= wr_accept;
            if (wr_accept) begin
                weight_wr_data <= s.data;
                weight_wr_addr <= cur_base + idx;
            end
            done <= 1'b0;

            unique case (state)
                ST_IDLE: begin
                    if (start) begin
                        state <= ST_KERNEL;
                        idx   <= 32'd0;
                        busy  <= 1'b1;
`ifdef CONV_WEIGHT_LOADER_CHECKSUM_EN
                        sum          <= 16'd0;
                        checksum_err <= 1'b0;
`endif
                    end
                end

                ST_KERNEL, ST_BIAS, ST_MACC, ST_SCALE: begin
                    if (wr_accept) begin
`ifdef CONV_WEIGHT_LOADER_CHECKSUM_EN
                        sum <= sum + s.data;
`endif
                        if (region_last) begin
                            state <= next_region;
                            idx   <= 32'd0;
                        end else begin
                            idx <= idx + 32'd1;
                        end
                    end
                end

`ifdef CONV_WEIGHT_LOADER_CHECKSUM_EN
                ST_CHECK: begin
                    // Trailing word is compared against the running sum, never written
                    if (chk_accept) begin
                        if (s.data != sum) begin
                            checksum_err <= 1'b1;
                        end
                        state <= ST_DONE;
                        idx   <= 32'd0;
                    end
                end
`endif

                ST_DONE: begin
                    // The last write strobe is on the port this cycle; done follows it
                    done  <= 1'b1;
                    busy  <= 1'b0;
                    state <= ST_IDLE;
                end

                default: begin
                    state <= ST_IDLE;
                    idx   <= 32'd0;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule
